// File: rtl/out_port_buffer.sv
// -----------------------------------------------------------------------------
// out_port_buffer
//
// Output-port stage that sits directly behind the processor's OUT path. Every
// cycle outSignalEn is high, the word on outPortData is queued in a small FIFO.
// Queued words are handed, in order, to an external listener over a
// valid/ready handshake. This keeps single-cycle OUT instructions from
// stalling on a slow or back-pressuring peripheral. Full and overflow status
// are reported back to the core.
//
// Ports
//   clk              system clock; all state updates on the rising edge
//   reset            synchronous, active-high reset
//   outPortData      word from the processor's OUT path
//   outSignalEn      push strobe; one word per cycle while high
//   ext_data         head-of-queue word (zero when the queue is empty)
//   ext_valid        ext_data holds a valid word
//   ext_ready        peripheral accepts ext_data this cycle
//   out_full         occupancy == DEPTH
//   out_almost_full  occupancy >= DEPTH-1
//   out_count        current occupancy, 0..DEPTH
//   out_overflow     sticky flag: a push was dropped because the queue was full
//   clear_ovf        clears out_overflow (and the statistics counters)
//
// Build option
//   OUT_PORT_STATS_EN  When defined, two extra outputs are added:
//                      out_sent_cnt (words delivered) and out_drop_cnt (pushes
//                      dropped). Both are 16-bit saturating counters.
// -----------------------------------------------------------------------------
module out_port_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] outPortData,
    input  logic              outSignalEn,
    output logic [DATA_W-1:0] ext_data,
    output logic              ext_valid,
    input  logic              ext_ready,
    output logic              out_full,
    output logic              out_almost_full,
    output logic [PTR_W:0]    out_count,
    output logic              out_overflow,
    input  logic              clear_ovf
`ifdef OUT_PORT_STATS_EN
    ,
    output logic [15:0]       out_sent_cnt,
    output logic [15:0]       out_drop_cnt
`endif
);

    localparam logic [PTR_W:0] FULL_COUNT   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ALMOST_COUNT = FULL_COUNT - 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W:0]    count;
    logic              overflow;

    logic pushReq;
    logic pop;
    logic pushAccept;
    logic pushDrop;

    always_comb begin
        // NOTE: every signal is assigned on every pass through this block, so
        // no latch can be inferred for any of them.
        // An X on the strobe (undriven OUT path at power-up) compares unequal
        // to 1, so it is treated as "no push"; synthesis treats === as ==.
        pushReq    = (outSignalEn === 1'b1);
        pop        = ext_valid && ext_ready;
        // A full queue can still accept a push if the head leaves this cycle.
        pushAccept = pushReq && ((count < FULL_COUNT) || pop);
        pushDrop   = pushReq && !pushAccept;
    end

    // Outputs are decoded from registered state only: no push-to-output bypass.
    assign ext_valid       = (count != '0);
    assign ext_data        = ext_valid ? mem[rdPtr] : '0;
    assign out_full        = (count == FULL_COUNT);
    assign out_almost_full = (count >= ALMOST_COUNT);
    assign out_count       = count;
    assign out_overflow    = overflow;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits wide, so they wrap freely.
            if (pushAccept) wrPtr <= wrPtr + 1'b1;
            if (pop)        rdPtr <= rdPtr + 1'b1;

            if (pushAccept && !pop)      count <= count + 1'b1;
            else if (pop && !pushAccept) count <= count - 1'b1;

            // A drop in the same cycle as clear_ovf leaves the flag set.
            if (pushDrop)       overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because the pointers and count are reset, and this keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && pushAccept) mem[wrPtr] <= outPortData;
    end

`ifdef OUT_PORT_STATS_EN
    // Saturating event counters. An event in the same cycle as clear_ovf is
    // counted rather than cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_sent_cnt <= '0;
            out_drop_cnt <= '0;
        end else begin
            if (pop) begin
                if (out_sent_cnt != 16'hFFFF) out_sent_cnt <= out_sent_cnt + 16'd1;
            end else if (clear_ovf) begin
                out_sent_cnt <= '0;
            end

            if (pushDrop) begin
                if (out_drop_cnt != 16'hFFFF) out_drop_cnt <= out_drop_cnt + 16'd1;
            end else if (clear_ovf) begin
                out_drop_cnt <= '0;
            end
        end
    end
`else
    // Statistics disabled: no counters and no extra ports are built.
`endif

endmodule

// File: tb/tb_out_port_buffer.sv
// -----------------------------------------------------------------------------
// tb_out_port_buffer
//
// Directed testbench for out_port_buffer (DATA_W=16, DEPTH=8). Inputs are
// driven and outputs sampled on the falling edge; the DUT updates on the
// rising edge. With OUT_PORT_STATS_EN defined the statistics counters are
// exercised as well.
// -----------------------------------------------------------------------------
module tb_out_port_buffer;

    logic        clk;
    logic        reset;
    logic [15:0] outPortData;
    logic        outSignalEn;
    logic [15:0] ext_data;
    logic        ext_valid;
    logic        ext_ready;
    logic        out_full;
    logic        out_almost_full;
    logic [3:0]  out_count;
    logic        out_overflow;
    logic        clear_ovf;
`ifdef OUT_PORT_STATS_EN
    logic [15:0] out_sent_cnt;
    logic [15:0] out_drop_cnt;
`endif

    int numChecks = 0;
    int numFails  = 0;

    out_port_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .outPortData     (outPortData),
        .outSignalEn     (outSignalEn),
        .ext_data        (ext_data),
        .ext_valid       (ext_valid),
        .ext_ready       (ext_ready),
        .out_full        (out_full),
        .out_almost_full (out_almost_full),
        .out_count       (out_count),
        .out_overflow    (out_overflow),
        .clear_ovf       (clear_ovf)
`ifdef OUT_PORT_STATS_EN
        ,
        .out_sent_cnt    (out_sent_cnt),
        .out_drop_cnt    (out_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return at the falling edge where outputs are stable.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        outSignalEn = 1'b0;
        outPortData = 16'h0000;
        ext_ready   = 1'b0;
        clear_ovf   = 1'b0;
    endtask

    task automatic fillFull();
        for (int i = 1; i <= 8; i++) begin
            outSignalEn = 1'b1;
            outPortData = 16'(i);
            step();
        end
        outSignalEn = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        outSignalEn = 1'b1;
        outPortData = 16'hFFFF;
        ext_ready   = 1'b1;
        clear_ovf   = 1'b0;
        step();
        step();
        numChecks++; if (ext_valid !== 1'b0) begin numFails++; $display("FAIL reset_valid: got %b expected 0", ext_valid); end
        numChecks++; if (ext_data !== 16'h0000) begin numFails++; $display("FAIL reset_data: got %h expected 0000", ext_data); end
        numChecks++; if (out_count !== 4'd0) begin numFails++; $display("FAIL reset_count: got %0d expected 0", out_count); end
        numChecks++; if (out_full !== 1'b0) begin numFails++; $display("FAIL reset_full: got %b expected 0", out_full); end
        numChecks++; if (out_almost_full !== 1'b0) begin numFails++; $display("FAIL reset_almost_full: got %b expected 0", out_almost_full); end
        numChecks++; if (out_overflow !== 1'b0) begin numFails++; $display("FAIL reset_overflow: got %b expected 0", out_overflow); end
        reset = 1'b0;
        idleInputs();
        step();
        numChecks++; if (out_count !== 4'd0) begin numFails++; $display("FAIL reset_idle_count: got %0d expected 0", out_count); end
    endtask

    task automatic test_single();
        outSignalEn = 1'b1;
        outPortData = 16'h1234;
        step();
        outSignalEn = 1'b0;
        numChecks++; if (ext_valid !== 1'b1) begin numFails++; $display("FAIL single_valid: got %b expected 1", ext_valid); end
        numChecks++; if (ext_data !== 16'h1234) begin numFails++; $display("FAIL single_data: got %h expected 1234", ext_data); end
        numChecks++; if (out_count !== 4'd1) begin numFails++; $display("FAIL single_count: got %0d expected 1", out_count); end
        // Held without ready: head must not move.
        step();
        numChecks++; if (ext_data !== 16'h1234) begin numFails++; $display("FAIL single_hold: got %h expected 1234", ext_data); end
        ext_ready = 1'b1;
        step();
        numChecks++; if (ext_valid !== 1'b0) begin numFails++; $display("FAIL single_pop_valid: got %b expected 0", ext_valid); end
        numChecks++; if (out_count !== 4'd0) begin numFails++; $display("FAIL single_pop_count: got %0d expected 0", out_count); end
        // Ready on an empty queue changes nothing.
        step();
        numChecks++; if (out_count !== 4'd0) begin numFails++; $display("FAIL empty_ready_count: got %0d expected 0", out_count); end
        numChecks++; if (ext_data !== 16'h0000) begin numFails++; $display("FAIL empty_ready_data: got %h expected 0000", ext_data); end
        // Push with ready on an empty queue: push only, no same-cycle pop.
        outSignalEn = 1'b1;
        outPortData = 16'h5A5A;
        step();
        outSignalEn = 1'b0;
        ext_ready   = 1'b0;
        numChecks++; if (ext_data !== 16'h5A5A) begin numFails++; $display("FAIL nobypass_data: got %h expected 5a5a", ext_data); end
        numChecks++; if (out_count !== 4'd1) begin numFails++; $display("FAIL nobypass_count: got %0d expected 1", out_count); end
        ext_ready = 1'b1;
        step();
        ext_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            outSignalEn = 1'b1;
            outPortData = 16'(i);
            step();
            numChecks++; if (out_count !== 4'(i)) begin numFails++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, out_count, i); end
            numChecks++; if (out_almost_full !== (i >= 7)) begin numFails++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, out_almost_full, (i >= 7)); end
            numChecks++; if (out_full !== (i == 8)) begin numFails++; $display("FAIL fill_full[%0d]: got %b expected %b", i, out_full, (i == 8)); end
        end
        outSignalEn = 1'b0;
        ext_ready   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            numChecks++; if (ext_valid !== 1'b1) begin numFails++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, ext_valid); end
            numChecks++; if (ext_data !== 16'(i)) begin numFails++; $display("FAIL drain_data[%0d]: got %h expected %h", i, ext_data, 16'(i)); end
            step();
        end
        ext_ready = 1'b0;
        numChecks++; if (ext_valid !== 1'b0) begin numFails++; $display("FAIL drain_done_valid: got %b expected 0", ext_valid); end
        numChecks++; if (out_count !== 4'd0) begin numFails++; $display("FAIL drain_done_count: got %0d expected 0", out_count); end
    endtask

    task automatic test_overflow();
        fillFull();
        outSignalEn = 1'b1;
        outPortData = 16'hDEAD;
        step();
        outSignalEn = 1'b0;
        numChecks++; if (out_overflow !== 1'b1) begin numFails++; $display("FAIL ovf_set: got %b expected 1", out_overflow); end
        numChecks++; if (out_count !== 4'd8) begin numFails++; $display("FAIL ovf_count: got %0d expected 8", out_count); end
        numChecks++; if (ext_data !== 16'h0001) begin numFails++; $display("FAIL ovf_head: got %h expected 0001", ext_data); end
        // Drop and clear in the same cycle: set wins.
        outSignalEn = 1'b1;
        outPortData = 16'hDEAD;
        clear_ovf   = 1'b1;
        step();
        outSignalEn = 1'b0;
        numChecks++; if (out_overflow !== 1'b1) begin numFails++; $display("FAIL ovf_set_wins: got %b expected 1", out_overflow); end
        step();
        clear_ovf = 1'b0;
        numChecks++; if (out_overflow !== 1'b0) begin numFails++; $display("FAIL ovf_clear: got %b expected 0", out_overflow); end
        numChecks++; if (out_count !== 4'd8) begin numFails++; $display("FAIL ovf_clear_count: got %0d expected 8", out_count); end
    endtask

    // Expects the queue full with 0001..0008 on entry.
    task automatic test_full_push_pop();
        logic [15:0] expSeq [8];
        outSignalEn = 1'b1;
        outPortData = 16'hBEEF;
        ext_ready   = 1'b1;
        step();
        outSignalEn = 1'b0;
        ext_ready   = 1'b0;
        numChecks++; if (out_count !== 4'd8) begin numFails++; $display("FAIL pushpop_count: got %0d expected 8", out_count); end
        numChecks++; if (out_overflow !== 1'b0) begin numFails++; $display("FAIL pushpop_overflow: got %b expected 0", out_overflow); end
        expSeq = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'hBEEF};
        ext_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            numChecks++; if (ext_data !== expSeq[i]) begin numFails++; $display("FAIL pushpop_drain[%0d]: got %h expected %h", i, ext_data, expSeq[i]); end
            step();
        end
        ext_ready = 1'b0;
        numChecks++; if (ext_valid !== 1'b0) begin numFails++; $display("FAIL pushpop_empty: got %b expected 0", ext_valid); end
    endtask

    task automatic test_reset_mid();
        outSignalEn = 1'b1;
        outPortData = 16'h00AA;
        step();
        outPortData = 16'h00BB;
        step();
        numChecks++; if (out_count !== 4'd2) begin numFails++; $display("FAIL midrst_pre_count: got %0d expected 2", out_count); end
        // Reset with push and ready asserted: inputs are ignored.
        reset       = 1'b1;
        outPortData = 16'h00EE;
        ext_ready   = 1'b1;
        step();
        reset = 1'b0;
        idleInputs();
        numChecks++; if (ext_valid !== 1'b0) begin numFails++; $display("FAIL midrst_valid: got %b expected 0", ext_valid); end
        numChecks++; if (out_count !== 4'd0) begin numFails++; $display("FAIL midrst_count: got %0d expected 0", out_count); end
        numChecks++; if (out_overflow !== 1'b0) begin numFails++; $display("FAIL midrst_overflow: got %b expected 0", out_overflow); end
        outSignalEn = 1'b1;
        outPortData = 16'h00CC;
        step();
        outSignalEn = 1'b0;
        numChecks++; if (ext_data !== 16'h00CC) begin numFails++; $display("FAIL midrst_first: got %h expected 00cc", ext_data); end
        numChecks++; if (out_count !== 4'd1) begin numFails++; $display("FAIL midrst_first_count: got %0d expected 1", out_count); end
        ext_ready = 1'b1;
        step();
        ext_ready = 1'b0;
    endtask

`ifdef OUT_PORT_STATS_EN
    task automatic test_stats();
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        numChecks++; if (out_sent_cnt !== 16'd0) begin numFails++; $display("FAIL stats_clear0_sent: got %0d expected 0", out_sent_cnt); end
        numChecks++; if (out_drop_cnt !== 16'd0) begin numFails++; $display("FAIL stats_clear0_drop: got %0d expected 0", out_drop_cnt); end
        for (int i = 1; i <= 10; i++) begin
            outSignalEn = 1'b1;
            outPortData = 16'(i);
            step();
        end
        outSignalEn = 1'b0;
        numChecks++; if (out_drop_cnt !== 16'd2) begin numFails++; $display("FAIL stats_drop: got %0d expected 2", out_drop_cnt); end
        numChecks++; if (out_overflow !== 1'b1) begin numFails++; $display("FAIL stats_overflow: got %b expected 1", out_overflow); end
        ext_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        ext_ready = 1'b0;
        numChecks++; if (out_sent_cnt !== 16'd8) begin numFails++; $display("FAIL stats_sent: got %0d expected 8", out_sent_cnt); end
        numChecks++; if (out_count !== 4'd0) begin numFails++; $display("FAIL stats_empty: got %0d expected 0", out_count); end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        numChecks++; if (out_sent_cnt !== 16'd0) begin numFails++; $display("FAIL stats_clear_sent: got %0d expected 0", out_sent_cnt); end
        numChecks++; if (out_drop_cnt !== 16'd0) begin numFails++; $display("FAIL stats_clear_drop: got %0d expected 0", out_drop_cnt); end
        numChecks++; if (out_overflow !== 1'b0) begin numFails++; $display("FAIL stats_clear_ovf: got %b expected 0", out_overflow); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idleInputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
`ifdef OUT_PORT_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/out_port_buffer.md
Name: out_port_buffer

Overview:
- Output-port stage directly downstream of the processor's OUT path.
- Captures each 16-bit word the processor presents on outPortData while outSignalEn is high, and queues it in a FIFO.
- Delivers words in order to an external listener over a valid/ready handshake.
- Decouples single-cycle OUT instructions from a slow or back-pressuring peripheral, and reports full/overflow status to the core.

Parameters:
- DATA_W, 16, word width; matches outPortData.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- PTR_W, 3, pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- outPortData  input  DATA_W  word from the processor's OUT path.
- outSignalEn  input  1  push strobe; one word per cycle while high.
- ext_data  output  DATA_W  head-of-queue word to the peripheral.
- ext_valid  output  1  ext_data holds a valid word.
- ext_ready  input  1  peripheral accepts ext_data this cycle.
- out_full  output  1  count == DEPTH.
- out_almost_full  output  1  count >= DEPTH-1; available for hazard/stall logic.
- out_count  output  PTR_W+1  current occupancy, 0..DEPTH.
- out_overflow  output  1  sticky: a push was dropped.
- clear_ovf  input  1  clears out_overflow.

Behaviour:
- Storage: DEPTH x DATA_W register array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter count (PTR_W+1 bits).
- Pointers wrap modulo DEPTH naturally (PTR_W bits).
- push_req = outSignalEn. pop = ext_valid & ext_ready.
- push accepted = push_req & (count < DEPTH | pop).
- Accepted push: mem[wr_ptr] <= outPortData; wr_ptr increments.
- pop: rd_ptr increments.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- ext_valid = (count != 0); ext_data = mem[rd_ptr] when ext_valid, else all zeros. Both are combinational from registered state.
- Latency: a word pushed at edge N appears on ext_data/ext_valid after edge N. There is no same-cycle bypass, so an empty FIFO with push and ext_ready high performs the push only.
- Full, push, no pop: word dropped; state unchanged; out_overflow <= 1 at that edge.
- Full, push and pop together: both happen; count stays DEPTH; no overflow.
- Empty with ext_ready high: no pop, no state change.
- ext_valid stays high and ext_data stays stable until accepted; the head is never reordered.
- out_overflow: set by a dropped push, cleared by clear_ovf. If both occur in the same cycle, set wins.
- out_full and out_almost_full are combinational from count.
- Reset (any cycle, including mid-transfer or with push asserted) forces wr_ptr = rd_ptr = 0, count = 0, out_overflow = 0. Array contents need not be cleared.
- Resulting reset outputs: ext_valid = 0, ext_data = 0, out_full = 0, out_almost_full = 0 (since DEPTH >= 2), out_count = 0. Inputs during reset are ignored.
- X-safety: outSignalEn === X is treated as no push, so an undriven OUT path at power-up does not corrupt the queue.

Optional Feature:
- Macro: OUT_PORT_STATS_EN.
- Defined: adds two outputs, out_sent_cnt [15:0] and out_drop_cnt [15:0].
  - out_sent_cnt increments on every pop; out_drop_cnt increments on every dropped push.
  - Both saturate at 16'hFFFF, reset to 0, and are cleared by clear_ovf at the next edge. Increment wins over clear in the same cycle.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then push 16'h1234 for one cycle with ext_ready=0 -> next cycle ext_valid=1, ext_data=16'h1234, out_count=1. Raise ext_ready for 1 cycle -> ext_valid=0, out_count=0.
- ext_ready=0, push 16'h0001..16'h0008 on consecutive cycles -> out_full=1, out_count=8. out_almost_full rises after the 7th push. Then ext_ready=1 for 8 cycles -> ext_data sequence 0001..0008 in order, ext_valid low afterward.
- FIFO full, push 16'hDEAD with ext_ready=0 -> out_overflow=1, out_count=8, head still 16'h0001. Pulse clear_ovf -> out_overflow=0.
- FIFO full, push 16'hBEEF with ext_ready=1 same cycle -> 16'h0001 consumed, count stays 8, no overflow, 16'hBEEF delivered 8th.
- Push 16'h00AA and 16'h00BB, then assert reset while ext_valid=1 -> next cycle ext_valid=0, out_count=0, out_overflow=0. A subsequent push of 16'h00CC is the first word delivered.
- OUT_PORT_STATS_EN defined: 10 pushes into DEPTH=8 with ext_ready=0, then drain -> out_drop_cnt=2, out_sent_cnt=8. clear_ovf -> both 0.
